// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-outstanding memory port between instruction and data requesters
module mem_arbiter #(
   parameter int MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_ready,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ready,
   output logic        m_en,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   output logic        stall
);
   localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3;
   localparam logic [2:0] LAT = 3'(MEM_LAT);
   logic [1:0] state;
   logic [2:0] cnt;
   logic       last_grant;
   logic       owner;
   logic       we;
   logic       grant_d;
   assign grant_d = d_req & (~i_req | ~last_grant);
   assign i_ready = (state == RESP) & ~owner;
   assign d_ready = (state == RESP) & owner;
   assign stall   = (i_req & ~i_ready) | (d_req & ~d_ready);
   // grant in IDLE, strobe memory in ISSUE, count latency in WAIT, pulse the owner's ready in RESP
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= 3'd0;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         we         <= 1'b0;
         m_en       <= 1'b0;
         m_we       <= 1'b0;
         m_addr     <= 32'd0;
         m_wdata    <= 32'd0;
         i_rdata    <= 32'd0;
         d_rdata    <= 32'd0;
      end else begin
         m_en <= 1'b0;
         m_we <= 1'b0;
         case (state)
            IDLE: if (i_req | d_req) begin
               state      <= ISSUE;
               owner      <= grant_d;
               last_grant <= grant_d;
               we         <= grant_d & d_we;
               m_en       <= 1'b1;
               m_we       <= grant_d & d_we;
               m_addr     <= grant_d ? d_addr : i_addr;
               m_wdata    <= grant_d ? d_wdata : m_wdata;
            end
            ISSUE: begin
               state <= WAIT;
               cnt   <= 3'd1;
            end
            WAIT: begin
               cnt <= cnt + 3'd1;
               if (cnt == LAT) begin
                  state   <= RESP;
                  d_rdata <= (!we && owner) ? m_rdata : d_rdata;
                  i_rdata <= (!we && !owner) ? m_rdata : i_rdata;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
